axi_slave_mem_bridge: RTL and testbench

- AXI4 slave (responder) that terminates the burst traffic issued by the vsdma AXI master and turns it into a simple dual-port synchronous memory interface (BRAM or line buffer).
- Used as the on-chip target in place of the DDR controller, for frame-buffer prototyping and for closed-loop simulation of the vsdma path.
- Write and read channels run independently and concurrently. Supports INCR bursts only.

---
 rtl/axi_slave_mem_bridge_if.sv | 59 +++++
 rtl/axi_slave_mem_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_slave_mem_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_mem_bridge_if.sv
// AXI4 write/read channel bundle between a burst master and the memory bridge.
// Signal names follow the AXI slave-port naming of the bridge.
interface axi_slave_mem_bridge_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
);
  logic [ID_W-1:0]     S_AXI_AWID;
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [7:0]          S_AXI_AWLEN;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WLAST;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [ID_W-1:0]     S_AXI_BID;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ID_W-1:0]     S_AXI_ARID;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [7:0]          S_AXI_ARLEN;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [ID_W-1:0]     S_AXI_RID;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RLAST;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_slave_mem_bridge.sv
// AXI4 INCR-burst slave terminating on a dual-port synchronous memory.
// Write and read channels are independent FSMs; reads go through a 2-entry output FIFO.
module axi_slave_mem_bridge #(
  parameter int S_AXI_ID_WIDTH   = 4,
  parameter int S_AXI_ADDR_WIDTH = 28,
  parameter int S_AXI_DATA_WIDTH = 256,
  parameter int MEM_ADDR_WIDTH   = 10,
  parameter int BEAT_INC         = S_AXI_DATA_WIDTH / 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  axi_slave_mem_bridge_if.slave         s_axi,
  output logic                          mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_waddr,
  output logic [S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic [S_AXI_DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                          mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [S_AXI_DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]                    dbg_w_state,
  output logic                          dbg_r_state
);

  // Handshakes: a transfer happens on a rising clock edge where VALID and READY are
  // both high; a source holds VALID and its payload stable until that edge.

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_e;

  logic [MEM_ADDR_WIDTH-1:0] aw_word, ar_word;
  assign aw_word = MEM_ADDR_WIDTH'(s_axi.S_AXI_AWADDR / S_AXI_ADDR_WIDTH'(BEAT_INC));
  assign ar_word = MEM_ADDR_WIDTH'(s_axi.S_AXI_ARADDR / S_AXI_ADDR_WIDTH'(BEAT_INC));

  // ---------------- write channel ----------------
  w_state_e                  w_state_q, w_state_d;
  logic [MEM_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]                w_len_q, w_len_d;
  logic [8:0]                w_cnt_q, w_cnt_d;
  logic                      w_err_q, w_err_d;
  logic [S_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
  logic                      aw_ready, w_ready, b_valid, w_final;
  logic [1:0]                b_resp;

  assign w_final = (w_cnt_q == {1'b0, w_len_q});

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    w_id_d    = w_id_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_resp    = 2'b00;
    mem_wen   = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (s_axi.S_AXI_AWVALID) begin
          w_addr_d  = aw_word;
          w_len_d   = s_axi.S_AXI_AWLEN;
          w_id_d    = s_axi.S_AXI_AWID;
          w_cnt_d   = 9'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (s_axi.S_AXI_WVALID) begin
          mem_wen  = 1'b1;
          w_addr_d = w_addr_q + MEM_ADDR_WIDTH'(1);
          w_cnt_d  = w_cnt_q + 9'd1;
          // The beat count ends the burst; a misplaced WLAST is only reported.
          if (s_axi.S_AXI_WLAST != w_final) w_err_d = 1'b1;
          if (w_final) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        b_resp  = w_err_q ? 2'b10 : 2'b00;
        if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      w_id_q    <= w_id_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = b_valid;
  assign s_axi.S_AXI_BRESP   = b_resp;
  assign s_axi.S_AXI_BID     = w_id_q;
  assign mem_waddr           = w_addr_q;
  assign mem_wdata           = s_axi.S_AXI_WDATA;
  assign mem_wstrb           = s_axi.S_AXI_WSTRB;

  // ---------------- read channel ----------------
  r_state_e                    r_state_q, r_state_d;
  logic [MEM_ADDR_WIDTH-1:0]   r_addr_q, r_addr_d;
  logic [7:0]                  r_len_q, r_len_d;
  logic [S_AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [8:0]                  r_issued_q, r_issued_d;
  logic [8:0]                  r_beat_q, r_beat_d;
  logic                        r_inflight_q, r_inflight_d;
  logic [S_AXI_DATA_WIDTH-1:0] fifo_data_q [2];
  logic [S_AXI_DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]                  fifo_last_q, fifo_last_d;
  logic                        fifo_wptr_q, fifo_wptr_d;
  logic                        fifo_rptr_q, fifo_rptr_d;
  logic [1:0]                  fifo_cnt_q, fifo_cnt_d;
  logic                        ar_ready, r_valid, fifo_push, fifo_pop, credit_ok;
  logic [1:0]                  outstanding;

  assign r_valid     = (fifo_cnt_q != 2'd0);
  assign fifo_pop    = r_valid && s_axi.S_AXI_RREADY;
  assign fifo_push   = r_inflight_q;
  assign outstanding = fifo_cnt_q + {1'b0, r_inflight_q};
  // A pop this cycle frees a slot in time for the word issued now, keeping 1 beat/cycle.
  assign credit_ok   = (outstanding < 2'd2) || ((outstanding == 2'd2) && fifo_pop);

  always_comb begin
    r_state_d    = r_state_q;
    r_addr_d     = r_addr_q;
    r_len_d      = r_len_q;
    r_id_d       = r_id_q;
    r_issued_d   = r_issued_q;
    r_beat_d     = r_beat_q;
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    fifo_wptr_d  = fifo_wptr_q;
    fifo_rptr_d  = fifo_rptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    ar_ready     = 1'b0;
    mem_ren      = 1'b0;
    mem_raddr    = r_addr_q;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        // The first beat is fetched in the AR handshake cycle itself.
        if (s_axi.S_AXI_ARVALID) begin
          mem_ren    = 1'b1;
          mem_raddr  = ar_word;
          r_addr_d   = ar_word + MEM_ADDR_WIDTH'(1);
          r_len_d    = s_axi.S_AXI_ARLEN;
          r_id_d     = s_axi.S_AXI_ARID;
          r_issued_d = 9'd1;
          r_beat_d   = 9'd0;
          r_state_d  = R_BURST;
        end
      end
      R_BURST: begin
        if ((r_issued_q <= {1'b0, r_len_q}) && credit_ok) begin
          mem_ren    = 1'b1;
          r_addr_d   = r_addr_q + MEM_ADDR_WIDTH'(1);
          r_issued_d = r_issued_q + 9'd1;
        end
        if (fifo_pop && fifo_last_q[fifo_rptr_q]) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    r_inflight_d = mem_ren;
    if (fifo_push) begin
      fifo_data_d[fifo_wptr_q] = mem_rdata;
      fifo_last_d[fifo_wptr_q] = (r_beat_q == {1'b0, r_len_q});
      fifo_wptr_d              = ~fifo_wptr_q;
      r_beat_d                 = r_beat_q + 9'd1;
    end
    if (fifo_pop) fifo_rptr_d = ~fifo_rptr_q;
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q    <= R_IDLE;
      r_addr_q     <= '0;
      r_len_q      <= '0;
      r_id_q       <= '0;
      r_issued_q   <= '0;
      r_beat_q     <= '0;
      r_inflight_q <= 1'b0;
      fifo_data_q  <= '{default: '0};
      fifo_last_q  <= '0;
      fifo_wptr_q  <= 1'b0;
      fifo_rptr_q  <= 1'b0;
      fifo_cnt_q   <= '0;
    end else begin
      r_state_q    <= r_state_d;
      r_addr_q     <= r_addr_d;
      r_len_q      <= r_len_d;
      r_id_q       <= r_id_d;
      r_issued_q   <= r_issued_d;
      r_beat_q     <= r_beat_d;
      r_inflight_q <= r_inflight_d;
      fifo_data_q  <= fifo_data_d;
      fifo_last_q  <= fifo_last_d;
      fifo_wptr_q  <= fifo_wptr_d;
      fifo_rptr_q  <= fifo_rptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = r_valid;
  assign s_axi.S_AXI_RDATA   = fifo_data_q[fifo_rptr_q];
  assign s_axi.S_AXI_RLAST   = r_valid & fifo_last_q[fifo_rptr_q];
  assign s_axi.S_AXI_RID     = r_id_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign dbg_w_state = w_state_q;
  assign dbg_r_state = r_state_q;

endmodule

// File: tb/tb_axi_slave_mem_bridge.sv
// Directed bench for axi_slave_mem_bridge: AXI driver tasks, a behavioural memory
// with one-cycle read latency, and per-scenario checks.
module tb_axi_slave_mem_bridge;
  localparam int IDW = 4;
  localparam int AW  = 28;
  localparam int DW  = 256;
  localparam int MAW = 10;
  localparam int BI  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi_slave_mem_bridge_if #(.ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic           mem_wen, mem_ren;
  logic [MAW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wstrb;
  logic [1:0]     dbg_w_state;
  logic           dbg_r_state;

  axi_slave_mem_bridge #(
    .S_AXI_ID_WIDTH(IDW), .S_AXI_ADDR_WIDTH(AW), .S_AXI_DATA_WIDTH(DW),
    .MEM_ADDR_WIDTH(MAW), .BEAT_INC(BI)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
  );

  // Behavioural memory: byte-enabled write, registered read
  logic [DW-1:0] mem [0:(1<<MAW)-1];
  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < DW/8; b++)
        if (mem_wstrb[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  // ---------------- observation ----------------
  int checks = 0;
  int errors = 0;

  int          wlog_addr[$];
  logic [31:0] wlog_data[$];
  always @(posedge clk) if (mem_wen) begin
    wlog_addr.push_back(int'(mem_waddr));
    wlog_data.push_back(mem_wdata[31:0]);
  end

  int rd_out = 0;
  int rd_out_max = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_out <= 0;
    else rd_out <= rd_out + int'(mem_ren) - int'(bus.S_AXI_RVALID && bus.S_AXI_RREADY);
  always @(negedge clk) if (rd_out > rd_out_max) rd_out_max = rd_out;

  logic [31:0] rd_data[$];
  logic        rd_last[$];
  int          rd_cyc[$];
  int          rd_lat, rd_hold_err, rd_id_bad;

  // ---------------- drivers ----------------
  task automatic do_write(input int word, input int len, input logic [3:0] id,
                          input int wlast_at, input int dbase,
                          output logic [1:0] bresp, output logic [3:0] bid);
    int n;
    bresp = 2'bxx;
    bid   = 4'bxxxx;
    wlog_addr.delete();
    wlog_data.delete();
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_AWADDR  = AW'(word * BI);
    bus.S_AXI_AWLEN   = 8'(len);
    bus.S_AXI_AWID    = id;
    #1; n = 0;
    while (!bus.S_AXI_AWREADY && n < 100) begin @(negedge clk); #1; n++; end
    if (!bus.S_AXI_AWREADY) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready=0 after %0d cycles, required 1", n);
      bus.S_AXI_AWVALID = 1'b0;
      return;
    end
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WDATA  = DW'(dbase + i);
      bus.S_AXI_WLAST  = (i == wlast_at);
      #1; n = 0;
      while (!bus.S_AXI_WREADY && n < 100) begin @(negedge clk); #1; n++; end
      if (!bus.S_AXI_WREADY) begin
        checks++; errors++;
        $display("FAIL w_timeout: wready=0 on beat %0d, required 1", i);
        bus.S_AXI_WVALID = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    #1; n = 0;
    while (!bus.S_AXI_BVALID && n < 100) begin @(negedge clk); #1; n++; end
    if (!bus.S_AXI_BVALID) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid=0 after %0d cycles, required 1", n);
      return;
    end
    bresp = bus.S_AXI_BRESP;
    bid   = bus.S_AXI_BID;
    @(negedge clk);
  endtask

  // mode 0: RREADY held high; mode 1: RREADY toggles with a 5-cycle stall at stall_at
  task automatic do_read(input int word, input int len, input logic [3:0] id,
                         input int mode, input int stall_at);
    int n, hs, got;
    logic prev_stall;
    logic [31:0] prev_data;
    logic prev_last;
    rd_data.delete(); rd_last.delete(); rd_cyc.delete();
    rd_lat = -1; rd_hold_err = 0; rd_id_bad = 0; rd_out_max = 0;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_ARADDR  = AW'(word * BI);
    bus.S_AXI_ARLEN   = 8'(len);
    bus.S_AXI_ARID    = id;
    #1; n = 0;
    while (!bus.S_AXI_ARREADY && n < 100) begin @(negedge clk); #1; n++; end
    if (!bus.S_AXI_ARREADY) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready=0 after %0d cycles, required 1", n);
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end
    hs = cyc;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    got = 0; n = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (got <= len && n < 400) begin
      if (mode == 0) bus.S_AXI_RREADY = 1'b1;
      else bus.S_AXI_RREADY = ((n % 2) == 0) && !(n >= stall_at && n < stall_at + 5);
      #1;
      if (prev_stall && (bus.S_AXI_RDATA[31:0] !== prev_data || bus.S_AXI_RLAST !== prev_last))
        rd_hold_err++;
      if (bus.S_AXI_RVALID && rd_lat < 0) rd_lat = cyc - hs;
      if (bus.S_AXI_RVALID && bus.S_AXI_RID !== id) rd_id_bad++;
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        rd_data.push_back(bus.S_AXI_RDATA[31:0]);
        rd_last.push_back(bus.S_AXI_RLAST);
        rd_cyc.push_back(cyc);
        got++;
      end
      prev_stall = bus.S_AXI_RVALID && !bus.S_AXI_RREADY;
      prev_data  = bus.S_AXI_RDATA[31:0];
      prev_last  = bus.S_AXI_RLAST;
      @(negedge clk);
      n++;
    end
    bus.S_AXI_RREADY = 1'b0;
    if (got <= len) begin
      checks++; errors++;
      $display("FAIL r_timeout: got %0d beats, required %0d", got, len + 1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.S_AXI_AWREADY !== 1'b1) begin errors++; $display("FAIL rst_awready: got %b want 1", bus.S_AXI_AWREADY); end
    checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL rst_arready: got %b want 1", bus.S_AXI_ARREADY); end
    checks++; if (bus.S_AXI_WREADY !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", bus.S_AXI_WREADY); end
    checks++; if (bus.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", bus.S_AXI_BVALID); end
    checks++; if (bus.S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL rst_bresp: got %b want 00", bus.S_AXI_BRESP); end
    checks++; if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RLAST !== 1'b0) begin errors++; $display("FAIL rst_rvalid_rlast: got %b%b want 00", bus.S_AXI_RVALID, bus.S_AXI_RLAST); end
    checks++; if (mem_wen !== 1'b0 || mem_ren !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got wen=%b ren=%b want 0 0", mem_wen, mem_ren); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got aw=%b ar=%b want 1 1", bus.S_AXI_AWREADY, bus.S_AXI_ARREADY); end
  endtask

  task automatic test_write_burst();
    logic [1:0] bresp; logic [3:0] bid;
    do_write(8, 15, 4'h5, 15, 0, bresp, bid);
    checks++; if (wlog_addr.size() != 16) begin errors++; $display("FAIL wr16_count: got %0d writes want 16", wlog_addr.size()); end
    for (int i = 0; i < wlog_addr.size() && i < 16; i++) begin
      checks++; if (wlog_addr[i] != 8 + i || wlog_data[i] !== 32'(i)) begin errors++; $display("FAIL wr16_beat%0d: got addr=%0d data=%0h want addr=%0d data=%0h", i, wlog_addr[i], wlog_data[i], 8 + i, i); end
    end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL wr16_bresp: got %b want 00", bresp); end
    checks++; if (bid !== 4'h5) begin errors++; $display("FAIL wr16_bid: got %h want 5", bid); end
    #1;
    checks++; if (bus.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL wr16_single_b: bvalid=%b after response, want 0", bus.S_AXI_BVALID); end
  endtask

  task automatic test_read_burst();
    do_read(8, 15, 4'h9, 0, 0);
    checks++; if (rd_data.size() != 16) begin errors++; $display("FAIL rd16_count: got %0d beats want 16", rd_data.size()); end
    for (int i = 0; i < rd_data.size() && i < 16; i++) begin
      checks++; if (rd_data[i] !== 32'(i) || rd_last[i] !== (i == 15)) begin errors++; $display("FAIL rd16_beat%0d: got data=%0h last=%b want data=%0h last=%b", i, rd_data[i], rd_last[i], i, (i == 15)); end
    end
    checks++; if (rd_lat != 2) begin errors++; $display("FAIL rd16_latency: got %0d cycles want 2", rd_lat); end
    checks++; if (rd_cyc.size() == 16 && rd_cyc[15] - rd_cyc[0] != 15) begin errors++; $display("FAIL rd16_throughput: got %0d cycles for 16 beats want 15", rd_cyc[15] - rd_cyc[0]); end
    checks++; if (rd_id_bad != 0) begin errors++; $display("FAIL rd16_rid: got %0d bad RID beats want 0", rd_id_bad); end
    #1;
    checks++; if (bus.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL rd16_arready_back: got %b want 1", bus.S_AXI_ARREADY); end
  endtask

  task automatic test_read_stall();
    do_read(8, 15, 4'hA, 1, $urandom_range(2, 10));
    checks++; if (rd_data.size() != 16) begin errors++; $display("FAIL rdst_count: got %0d beats want 16", rd_data.size()); end
    for (int i = 0; i < rd_data.size() && i < 16; i++) begin
      checks++; if (rd_data[i] !== 32'(i) || rd_last[i] !== (i == 15)) begin errors++; $display("FAIL rdst_beat%0d: got data=%0h last=%b want data=%0h last=%b", i, rd_data[i], rd_last[i], i, (i == 15)); end
    end
    checks++; if (rd_hold_err != 0) begin errors++; $display("FAIL rdst_hold: got %0d unstable stall cycles want 0", rd_hold_err); end
    checks++; if (rd_out_max > 2) begin errors++; $display("FAIL rdst_outstanding: got max %0d want <= 2", rd_out_max); end
  endtask

  task automatic test_wlast_error();
    logic [1:0] bresp; logic [3:0] bid;
    do_write(100, 3, 4'h2, 1, 32'h20, bresp, bid);
    checks++; if (wlog_addr.size() != 4) begin errors++; $display("FAIL wlerr_count: got %0d writes want 4", wlog_addr.size()); end
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL wlerr_bresp: got %b want 10", bresp); end
    do_write(100, 3, 4'h3, 3, 32'h30, bresp, bid);
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL wlok_bresp: got %b want 00", bresp); end
    checks++; if (bid !== 4'h3) begin errors++; $display("FAIL wlok_bid: got %h want 3", bid); end
  endtask

  task automatic test_wrap_and_single();
    logic [1:0] bresp; logic [3:0] bid;
    int exp_addr [4] = '{1022, 1023, 0, 1};
    do_write(1022, 3, 4'h6, 3, 32'hA0, bresp, bid);
    checks++; if (wlog_addr.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d writes want 4", wlog_addr.size()); end
    for (int i = 0; i < wlog_addr.size() && i < 4; i++) begin
      checks++; if (wlog_addr[i] != exp_addr[i]) begin errors++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, wlog_addr[i], exp_addr[i]); end
    end
    do_read(1022, 3, 4'h6, 0, 0);
    for (int i = 0; i < rd_data.size() && i < 4; i++) begin
      checks++; if (rd_data[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL wrap_rd%0d: got %0h want %0h", i, rd_data[i], 32'hA0 + i); end
    end
    do_write(300, 0, 4'hC, 0, 32'h55, bresp, bid);
    checks++; if (wlog_addr.size() != 1 || wlog_addr[0] != 300) begin errors++; $display("FAIL single_write: got %0d writes first addr %0d want 1 at 300", wlog_addr.size(), wlog_addr[0]); end
    checks++; if (bresp !== 2'b00 || bid !== 4'hC) begin errors++; $display("FAIL single_b: got resp=%b id=%h want 00 c", bresp, bid); end
    @(negedge clk); #1;
    checks++; if (bus.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL single_extra_b: bvalid=%b want 0", bus.S_AXI_BVALID); end
  endtask

  task automatic test_concurrent();
    logic [1:0] bresp; logic [3:0] bid;
    fork
      do_write(600, 15, 4'h7, 15, 32'h100, bresp, bid);
      do_read(8, 15, 4'h3, 0, 0);
    join
    checks++; if (wlog_addr.size() != 16 || wlog_addr[0] != 600 || wlog_addr[15] != 615) begin errors++; $display("FAIL conc_write: got %0d writes want 16 on 600..615", wlog_addr.size()); end
    checks++; if (bresp !== 2'b00 || bid !== 4'h7) begin errors++; $display("FAIL conc_b: got resp=%b id=%h want 00 7", bresp, bid); end
    checks++; if (rd_data.size() != 16) begin errors++; $display("FAIL conc_rd_count: got %0d want 16", rd_data.size()); end
    for (int i = 0; i < rd_data.size() && i < 16; i++) begin
      checks++; if (rd_data[i] !== 32'(i)) begin errors++; $display("FAIL conc_rd%0d: got %0h want %0h", i, rd_data[i], i); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] bresp; logic [3:0] bid;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = AW'(700 * BI); bus.S_AXI_AWLEN = 8'd15; bus.S_AXI_AWID = 4'h1;
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = AW'(8 * BI);  bus.S_AXI_ARLEN = 8'd15; bus.S_AXI_ARID = 4'h2;
    bus.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = DW'(32'h77); bus.S_AXI_WLAST = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.S_AXI_WREADY !== 1'b1 || bus.S_AXI_RVALID !== 1'b1) begin errors++; $display("FAIL mid_busy: got wready=%b rvalid=%b want 1 1", bus.S_AXI_WREADY, bus.S_AXI_RVALID); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got aw=%b ar=%b want 1 1", bus.S_AXI_AWREADY, bus.S_AXI_ARREADY); end
    checks++; if (bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_BVALID !== 1'b0) begin errors++; $display("FAIL mid_rst_w: got wready=%b bvalid=%b want 0 0", bus.S_AXI_WREADY, bus.S_AXI_BVALID); end
    checks++; if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_RLAST !== 1'b0) begin errors++; $display("FAIL mid_rst_r: got rvalid=%b rlast=%b want 0 0", bus.S_AXI_RVALID, bus.S_AXI_RLAST); end
    checks++; if (mem_wen !== 1'b0 || mem_ren !== 1'b0) begin errors++; $display("FAIL mid_rst_mem: got wen=%b ren=%b want 0 0", mem_wen, mem_ren); end
    bus.S_AXI_WVALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_ARREADY !== 1'b1) begin errors++; $display("FAIL mid_release: got aw=%b ar=%b want 1 1", bus.S_AXI_AWREADY, bus.S_AXI_ARREADY); end
    do_write(40, 3, 4'hE, 3, 32'hC0, bresp, bid);
    checks++; if (wlog_addr.size() != 4 || bresp !== 2'b00 || bid !== 4'hE) begin errors++; $display("FAIL fresh_write: got %0d writes resp=%b id=%h want 4 00 e", wlog_addr.size(), bresp, bid); end
    do_read(40, 3, 4'hD, 0, 0);
    checks++; if (rd_data.size() != 4) begin errors++; $display("FAIL fresh_rd_count: got %0d want 4", rd_data.size()); end
    for (int i = 0; i < rd_data.size() && i < 4; i++) begin
      checks++; if (rd_data[i] !== 32'hC0 + 32'(i) || rd_last[i] !== (i == 3)) begin errors++; $display("FAIL fresh_rd%0d: got data=%0h last=%b want %0h %b", i, rd_data[i], rd_last[i], 32'hC0 + i, (i == 3)); end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWID = '0;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '1; bus.S_AXI_WLAST = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARID = '0;
    bus.S_AXI_RREADY = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_read_stall();
    test_wlast_error();
    test_wrap_and_single();
    test_concurrent();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
